serial_tx_ctrl: RTL

Controller that serializes parallel words onto a single-bit line. It accepts one WIDTH-bit word at a time from an upstream producer over a valid/ready handshake and drives an internal parallel-load shift register MSB-first. It frames each transfer with a `frame` strobe, enforces a configurable idle gap between words, and reports completion. It sits between a parallel data source and the serial pin, owning the load/shift sequencing that a bare PISO register leaves to its user.

---
 rtl/serial_tx_pkg.sv | 18 +
 rtl/piso_shifter.sv | 27 ++
 rtl/serial_tx_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared FSM state type and reset values for serial_tx_ctrl
package serial_tx_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam state_t RST_STATE    = ST_IDLE;
  localparam logic   RST_IN_READY = 1'b1;
  localparam logic   RST_FRAME    = 1'b0;
  localparam logic   RST_BUSY     = 1'b0;
  localparam logic   RST_DONE     = 1'b0;

endpackage

// File: rtl/piso_shifter.sv
// rtl/piso_shifter.sv - parallel-load, MSB-first shift register with zero fill
module piso_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             sdo
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= d;
    end else if (shift) begin
      sr <= {sr[WIDTH-2:0], 1'b0};
    end
  end

  assign sdo = sr[WIDTH-1];

endmodule

// File: rtl/serial_tx_ctrl.sv
// rtl/serial_tx_ctrl.sv - valid/ready word-to-serial controller with framing and idle gap
// SERIAL_TX_PARITY_EN appends an even-parity bit after the LSB of every frame.
module serial_tx_ctrl
  import serial_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sdo,
  output logic             frame,
  output logic             busy,
  output logic             done
);

`ifdef SERIAL_TX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
  logic [FRAME_LEN-1:0] load_word;
  // Parity rides in the shifter as an extra LSB, so it is fixed at acceptance.
  assign load_word = {in_data, ^in_data};
`else
  localparam int FRAME_LEN = WIDTH;
  logic [FRAME_LEN-1:0] load_word;
  assign load_word = in_data;
`endif

  localparam int CW     = $clog2(WIDTH + 2);
  localparam int GW_RAW = $clog2(GAP_CYCLES + 1);
  localparam int GW     = (GW_RAW > CW) ? GW_RAW : CW;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [CW-1:0] BIT_LAST = CW'(FRAME_LEN - 1);
  localparam logic [GW-1:0] GAP_PRE  = GW'(GAP_LAST);

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic          accept;
  logic          shift;
  logic          sh_sdo;

  assign accept = in_valid && in_ready && (state == ST_IDLE);
  assign shift  = (state == ST_SHIFT);

  piso_shifter #(
    .WIDTH(FRAME_LEN)
  ) u_shifter (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (accept),
    .shift  (shift),
    .d      (load_word),
    .sdo    (sh_sdo)
  );

  // The shifter keeps stale zeros after a frame; gating by frame keeps sdo low.
  assign sdo = frame & sh_sdo;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= RST_STATE;
      in_ready <= RST_IN_READY;
      frame    <= RST_FRAME;
      busy     <= RST_BUSY;
      done     <= RST_DONE;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_SHIFT;
            in_ready <= 1'b0;
            frame    <= 1'b1;
            busy     <= 1'b1;
            bit_cnt  <= BIT_LAST;
          end
        end
        ST_SHIFT: begin
          if (bit_cnt == '0) begin
            frame   <= 1'b0;
            done    <= 1'b1;
            gap_cnt <= GAP_PRE;
            if (GAP_CYCLES > 0) begin
              state <= ST_GAP;
            end else begin
              state    <= ST_IDLE;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt - CW'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state    <= ST_IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
          frame    <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
